// File: rtl/ctrl_seq_pkg.sv
// Shared codes and control-vector signatures for the multicycle control-bus decoder.
// Packed vector layout: {spare, adr_src, ir_write, pc_update, reg_write, mem_write, branch, A, B, op, result_src}.
package ctrl_seq_pkg;

   localparam int VEC_W  = 15;
   localparam int NUM_ST = 12;

   typedef enum logic [3:0] {
      ST_SYNC     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEMADR   = 4'd3,
      ST_MEMREAD  = 4'd4,
      ST_MEMWB    = 4'd5,
      ST_MEMWRITE = 4'd6,
      ST_EXECR    = 4'd7,
      ST_EXECI    = 4'd8,
      ST_ALUWB    = 4'd9,
      ST_BEQ      = 4'd10,
      ST_JAL      = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE    = 3'd0,
      CLS_R       = 3'd1,
      CLS_I       = 3'd2,
      CLS_LW      = 3'd3,
      CLS_SW      = 3'd4,
      CLS_JAL     = 3'd5,
      CLS_BEQ     = 3'd6,
      CLS_ILLEGAL = 3'd7
   } class_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_SUCC  = 2'b01,
      ERR_WCONF = 2'b10
   } err_t;

   // Strobes are always compared (unlisted ones must be 0); selects only where listed.
   localparam logic [VEC_W-1:0] M_ALL  = 15'b0_111111_11_11_11_11;
   localparam logic [VEC_W-1:0] M_ABO  = 15'b0_111111_11_11_11_00;
   localparam logic [VEC_W-1:0] M_RS   = 15'b0_111111_00_00_00_11;

   localparam logic [VEC_W-1:0] V_FETCH    = 15'b0_011000_00_10_00_10;
   localparam logic [VEC_W-1:0] V_DECODE   = 15'b0_000000_01_01_00_00;
   localparam logic [VEC_W-1:0] V_MEMADR   = 15'b0_000000_10_01_00_00;
   localparam logic [VEC_W-1:0] V_MEMREAD  = 15'b0_100000_00_00_00_00;
   localparam logic [VEC_W-1:0] V_MEMWRITE = 15'b0_100010_00_00_00_00;
   localparam logic [VEC_W-1:0] V_MEMWB    = 15'b0_000100_00_00_00_01;
   localparam logic [VEC_W-1:0] V_EXECR    = 15'b0_000000_10_00_10_00;
   localparam logic [VEC_W-1:0] V_EXECI    = 15'b0_000000_10_01_10_00;
   localparam logic [VEC_W-1:0] V_ALUWB    = 15'b0_000100_00_00_00_00;
   localparam logic [VEC_W-1:0] V_BEQ      = 15'b0_000001_10_00_01_00;
   localparam logic [VEC_W-1:0] V_JAL      = 15'b0_001000_01_10_00_00;

   function automatic logic [VEC_W-1:0] sig_val(input state_t s);
      case (s)
         ST_FETCH:    return V_FETCH;
         ST_DECODE:   return V_DECODE;
         ST_MEMADR:   return V_MEMADR;
         ST_MEMREAD:  return V_MEMREAD;
         ST_MEMWRITE: return V_MEMWRITE;
         ST_MEMWB:    return V_MEMWB;
         ST_EXECR:    return V_EXECR;
         ST_EXECI:    return V_EXECI;
         ST_ALUWB:    return V_ALUWB;
         ST_BEQ:      return V_BEQ;
         ST_JAL:      return V_JAL;
         default:     return '0;
      endcase
   endfunction

   function automatic logic [VEC_W-1:0] sig_mask(input state_t s);
      case (s)
         ST_FETCH, ST_BEQ, ST_JAL:                return M_ALL;
         ST_DECODE, ST_MEMADR, ST_EXECR, ST_EXECI: return M_ABO;
         ST_MEMREAD, ST_MEMWRITE, ST_MEMWB, ST_ALUWB: return M_RS;
         default:                                 return M_ALL;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_seq_decoder_if.sv
// Control-bus tap between the multicycle FSM (master) and the sequence decoder (slave).
interface ctrl_seq_decoder_if #(parameter int CNT_W = 16);
   logic             en;
   logic             adr_src, ir_write, pc_update, reg_write, mem_write, branch;
   logic [1:0]       alu_src_a, alu_src_b, alu_op, result_src;
   logic [3:0]       cur_state;
   logic [2:0]       instr_class;
   logic             class_valid;
   logic             err;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] retired_cnt;

   modport master (
      output en, adr_src, ir_write, pc_update, reg_write, mem_write, branch,
             alu_src_a, alu_src_b, alu_op, result_src,
      input  cur_state, instr_class, class_valid, err, err_code, retired_cnt
   );

   modport slave (
      input  en, adr_src, ir_write, pc_update, reg_write, mem_write, branch,
             alu_src_a, alu_src_b, alu_op, result_src,
      output cur_state, instr_class, class_valid, err, err_code, retired_cnt
   );
endinterface

// File: rtl/ctrl_sig_match.sv
// Combinational test of a packed control vector against one state's signature.
module ctrl_sig_match
   import ctrl_seq_pkg::*;
(
   input  logic [VEC_W-1:0] vec_i,
   input  state_t           state_i,
   output logic             match_o
);
   assign match_o = ((vec_i ^ sig_val(state_i)) & sig_mask(state_i)) == '0;
endmodule

// File: rtl/ctrl_seq_decoder.sv
// Passive decoder: rebuilds the multicycle FSM state from its control outputs,
// reports instruction class at each boundary, counts retirements and flags illegal vectors.
module ctrl_seq_decoder
   import ctrl_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   ctrl_seq_decoder_if.slave bus
);

   logic [VEC_W-1:0]  vec;
   logic [NUM_ST-1:0] hit;

   state_t            state_q, state_d, nxt;
   class_t            class_q, class_d;
   err_t              code_q, code_d;
   logic              cv_q, cv_d, err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign vec = {1'b0, bus.adr_src, bus.ir_write, bus.pc_update, bus.reg_write,
                 bus.mem_write, bus.branch, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.result_src};

   assign hit[0] = 1'b0;
   for (genvar i = 1; i < NUM_ST; i++) begin : g_match
      ctrl_sig_match u_match (
         .vec_i   (vec),
         .state_i (state_t'(4'(i))),
         .match_o (hit[i])
      );
   end

   // Legal successor of the current state; ST_SYNC means nothing matched.
   always_comb begin
      nxt = ST_SYNC;
      case (state_q)
         ST_FETCH:  if (hit[ST_DECODE]) nxt = ST_DECODE;
         ST_DECODE: begin
            if (hit[ST_MEMADR])     nxt = ST_MEMADR;
            else if (hit[ST_EXECR]) nxt = ST_EXECR;
            else if (hit[ST_EXECI]) nxt = ST_EXECI;
            else if (hit[ST_BEQ])   nxt = ST_BEQ;
            else if (hit[ST_JAL])   nxt = ST_JAL;
            else if (hit[ST_FETCH]) nxt = ST_FETCH;
         end
         ST_MEMADR: begin
            if (hit[ST_MEMREAD])       nxt = ST_MEMREAD;
            else if (hit[ST_MEMWRITE]) nxt = ST_MEMWRITE;
         end
         ST_MEMREAD:          if (hit[ST_MEMWB]) nxt = ST_MEMWB;
         ST_EXECR, ST_EXECI:  if (hit[ST_ALUWB]) nxt = ST_ALUWB;
         ST_MEMWB, ST_MEMWRITE, ST_ALUWB, ST_BEQ, ST_JAL:
                              if (hit[ST_FETCH]) nxt = ST_FETCH;
         default:             nxt = ST_SYNC;
      endcase
   end

   always_comb begin
      state_d = state_q;
      class_d = class_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      cv_d    = 1'b0;
      err_d   = 1'b0;
      if (bus.en) begin
         if (state_q == ST_SYNC) begin
            if (hit[ST_FETCH]) state_d = ST_FETCH;
         end else if (bus.reg_write && bus.mem_write) begin
            state_d = ST_SYNC;
            err_d   = 1'b1;
            code_d  = ERR_WCONF;
         end else if (nxt == ST_SYNC) begin
            state_d = ST_SYNC;
            err_d   = 1'b1;
            code_d  = ERR_SUCC;
         end else begin
            state_d = nxt;
            cv_d    = 1'b1;
            case (nxt)
               ST_MEMWB:    class_d = CLS_LW;
               ST_MEMWRITE: class_d = CLS_SW;
               ST_ALUWB:    class_d = (state_q == ST_EXECI) ? CLS_I : CLS_R;
               ST_BEQ:      class_d = CLS_BEQ;
               ST_JAL:      class_d = CLS_JAL;
               default:     cv_d    = 1'b0;
            endcase
            if (cv_d) cnt_d = cnt_q + CNT_W'(1);
            // A decode that falls straight back to fetch is reported but not retired.
            if (nxt == ST_FETCH && state_q == ST_DECODE) begin
               cv_d    = 1'b1;
               class_d = CLS_ILLEGAL;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SYNC;
         class_q <= CLS_NONE;
         code_q  <= ERR_NONE;
         cnt_q   <= '0;
         cv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         cv_q    <= cv_d;
         err_q   <= err_d;
      end
   end

   assign bus.cur_state   = state_q;
   assign bus.instr_class = class_q;
   assign bus.class_valid = cv_q;
   assign bus.err         = err_q;
   assign bus.err_code    = code_q;
   assign bus.retired_cnt = cnt_q;

endmodule

// File: doc/ctrl_seq_decoder.md
# ctrl_seq_decoder

Passive decoder for the multicycle core's control bus. Samples the main FSM's per-cycle control outputs every clock and rebuilds the FSM state sequence from them. Reports the instruction class at each instruction boundary, counts retired instructions, and flags any control vector that is not a legal successor. Sits beside `mainFSM` in the multicycle datapath as the inverse mapping, from control sequence back to opcode class, for benches and on-chip debug.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clk` in 1 rising-edge clock, shared with `mainFSM`
- `rst` in 1 reset, asynchronous, active-high
- `en` in 1 sample enable; 0 freezes all state and outputs
- `adr_src, ir_write, pc_update, reg_write, mem_write, branch` in 1 each; FSM strobes
- `alu_src_a, alu_src_b, alu_op, result_src` in 2 each; FSM selects
- `cur_state` out 4 reconstructed state code
- `instr_class` out 3 class: 0 none, 1 R, 2 I, 3 LW, 4 SW, 5 JAL, 6 BEQ, 7 ILLEGAL
- `class_valid` out 1 one-cycle pulse; `instr_class` is updated
- `err` out 1 one-cycle pulse on protocol violation
- `err_code` out 2 01 = illegal successor, 10 = reg_write and mem_write both high; held until next `err`
- `retired_cnt` out CNT_W count of legally completed instructions

## Operation
- States: SYNC, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Signatures. Listed fields must match; strobes not listed must be 0; unlisted selects are don't-care.
  - FETCH: ir_write=1, pc_update=1, adr_src=0, A=00, B=10, op=00, result_src=10
  - DECODE: A=01, B=01, op=00
  - MEMADR: A=10, B=01, op=00
  - MEMREAD: adr_src=1, result_src=00
  - MEMWRITE: adr_src=1, mem_write=1, result_src=00
  - MEMWB: reg_write=1, result_src=01
  - EXECR: A=10, B=00, op=10
  - EXECI: A=10, B=01, op=10
  - ALUWB: reg_write=1, result_src=00
  - BEQ: branch=1, A=10, B=00, op=01, result_src=00
  - JAL: pc_update=1, A=01, B=10, op=00, result_src=00
- Legal successors. Only these are compared against the sampled vector.
  - SYNC→FETCH
  - FETCH→DECODE
  - DECODE→{MEMADR, EXECR, EXECI, BEQ, JAL, FETCH}
  - MEMADR→{MEMREAD, MEMWRITE}
  - MEMREAD→MEMWB
  - EXECR/EXECI→ALUWB
  - MEMWB/MEMWRITE/ALUWB/BEQ/JAL→FETCH
- SYNC ignores every vector except FETCH.
- Terminal states:
  - MEMWB→LW
  - MEMWRITE→SW
  - ALUWB→R or I, per the path taken
  - BEQ→BEQ
  - JAL→JAL
- On entering a terminal state: `class_valid`=1, `instr_class` set, `retired_cnt`+1, wrapping modulo 2^CNT_W.
- DECODE→FETCH: `class_valid`=1, `instr_class`=7, counter unchanged, no error.
- No match: `err`=1, `err_code`=01, next state SYNC, no class pulse.
- reg_write and mem_write both high: `err`=1, `err_code`=10, SYNC. This check takes precedence over the successor match.
- After an error, the first FETCH resynchronises.

## Timing
- All outputs are registered. A vector sampled at edge N is reflected in outputs after edge N.
- Reset values: `cur_state`=SYNC, `instr_class`=0, `class_valid`=0, `err`=0, `err_code`=00, `retired_cnt`=0.
- Reset mid-instruction returns to SYNC immediately; the partial instruction is never reported.
- `en`=0 cycles are invisible: no transitions, pulses deassert, the counter holds. A pulse never spans an `en`=0 cycle.
- `class_valid` and `err` are never high in the same cycle.

## Structure
- Package `ctrl_seq_pkg` holds:
  - state codes
  - class codes
  - err codes
  - per-state signature value/mask constants over a 15-bit packed control vector
- Sub-module `ctrl_sig_match`: combinational; packed vector plus state code in, match bit out. Instantiated once per candidate successor, or muxed by current state.

## Test plan
- Reset, then FETCH, DECODE, EXECR, ALUWB vectors → `class_valid` pulse with `instr_class`=1, `retired_cnt`=1.
- Back-to-back LW (5 states) then SW (4 states) → classes 3 then 4, `retired_cnt`=2, `err` never high.
- FETCH, DECODE, FETCH → `instr_class`=7, `retired_cnt` unchanged, `err`=0. Following JAL sequence → class 5.
- FETCH, DECODE, then MEMREAD vector → `err`=1, `err_code`=01, `cur_state`=SYNC. Next full BEQ sequence → class 6.
- Vector with reg_write=1 and mem_write=1 during MEMADR → `err_code`=10. `rst` pulse mid-EXECI → all outputs zero, SYNC.
- `en`=0 for 3 cycles inside an R instruction with random vectors → no effect, then normal completion. `CNT_W`=2 with 5 retirements → `retired_cnt`=1.
